// File: rtl/flapjack_mem_arb.sv
// ---------------------------------------------------------------------------
// flapjack_mem_arb
//
// Two-port round-robin arbiter in front of a single-port-per-direction BRAM
// with a registered read path. Port A is the core, port B the loader/debug
// port. One transaction is accepted per cycle; writes are issued to the BRAM
// the cycle after acceptance, reads return data two cycles after acceptance.
//
// Ports:
//   clk_sys           system clock, all flops rising-edge
//   rst_n             asynchronous active-low reset
//   a_req/a_we        port A request / write-enable
//   a_addr/a_wdata    port A address / write data
//   a_gnt             port A accept (combinational)
//   a_rvalid/a_rdata  port A read-data-valid / read data
//   b_*               same set for port B
//   mem_addr_read     BRAM read address (registered)
//   mem_addr_write    BRAM write address (registered)
//   mem_word_write    BRAM write data (registered)
//   mem_strobe        BRAM write enable (registered, one cycle per write)
//   mem_word_read     BRAM read data, valid one cycle after mem_addr_read
// ---------------------------------------------------------------------------
module flapjack_mem_arb #(
    parameter int WIDTH = 16,
    parameter int ADDRW = 16
) (
    input  logic             clk_sys,
    input  logic             rst_n,

    input  logic             a_req,
    input  logic             a_we,
    input  logic [ADDRW-1:0] a_addr,
    input  logic [WIDTH-1:0] a_wdata,
    output logic             a_gnt,
    output logic             a_rvalid,
    output logic [WIDTH-1:0] a_rdata,

    input  logic             b_req,
    input  logic             b_we,
    input  logic [ADDRW-1:0] b_addr,
    input  logic [WIDTH-1:0] b_wdata,
    output logic             b_gnt,
    output logic             b_rvalid,
    output logic [WIDTH-1:0] b_rdata,

    output logic [ADDRW-1:0] mem_addr_read,
    output logic [ADDRW-1:0] mem_addr_write,
    output logic [WIDTH-1:0] mem_word_write,
    output logic             mem_strobe,
    input  logic [WIDTH-1:0] mem_word_read
);

    typedef enum logic {
        PORT_A = 1'b0,
        PORT_B = 1'b1
    } port_e;

    port_e             last_gnt;
    port_e             last_gnt_next;

    logic              accept;
    logic              sel_we;
    logic [ADDRW-1:0]  sel_addr;
    logic [WIDTH-1:0]  sel_wdata;

    logic              tag1_valid;
    port_e             tag1_port;
    logic              tag2_valid;
    port_e             tag2_port;

    // Grant decision. A lone requester always wins; under contention the
    // port that did not win last time is chosen. Grants are forced low while
    // reset is held so nothing can be accepted before the first edge after
    // release.
    always_comb begin
        a_gnt = 1'b0;
        b_gnt = 1'b0;
        if (rst_n) begin
            if (a_req && (!b_req || last_gnt == PORT_B)) begin
                a_gnt = 1'b1;
            end else if (b_req) begin
                b_gnt = 1'b1;
            end
        end
    end

    // Mux the winning port's request fields onto a single internal bus.
    always_comb begin
        accept    = a_gnt || b_gnt;
        sel_we    = b_gnt ? b_we    : a_we;
        sel_addr  = b_gnt ? b_addr  : a_addr;
        sel_wdata = b_gnt ? b_wdata : a_wdata;
    end

    // Pointer next-state: only moves when a transaction is actually accepted.
    always_comb begin
        last_gnt_next = last_gnt;
        if (a_gnt) begin
            last_gnt_next = PORT_A;
        end else if (b_gnt) begin
            last_gnt_next = PORT_B;
        end
    end

    // Pointer register. Resetting to B makes A the winner of the first
    // contention after reset.
    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            last_gnt <= PORT_B;
        end else begin
            last_gnt <= last_gnt_next;
        end
    end

    // Write issue stage: an accepted write becomes a single-cycle strobe in
    // the following cycle. Address and data only change on a write so the
    // BRAM side sees stable values between writes.
    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            mem_strobe     <= 1'b0;
            mem_addr_write <= '0;
            mem_word_write <= '0;
        end else begin
            mem_strobe <= accept && sel_we;
            if (accept && sel_we) begin
                mem_addr_write <= sel_addr;
                mem_word_write <= sel_wdata;
            end
        end
    end

    // Read address register: loaded on an accepted read and held otherwise.
    // A write accepted one cycle earlier reaches the BRAM on the same edge
    // this address is captured, so the BRAM lookup on the next edge already
    // sees the new word.
    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            mem_addr_read <= '0;
        end else if (accept && !sel_we) begin
            mem_addr_read <= sel_addr;
        end
    end

    // Two-stage owner tag pipeline, matching the address register plus the
    // BRAM's own output register. Each stage records whether a read is in
    // flight and which port owns it, so responses come back in order.
    always_ff @(posedge clk_sys or negedge rst_n) begin
        if (!rst_n) begin
            tag1_valid <= 1'b0;
            tag1_port  <= PORT_A;
            tag2_valid <= 1'b0;
            tag2_port  <= PORT_A;
        end else begin
            tag1_valid <= accept && !sel_we;
            tag1_port  <= b_gnt ? PORT_B : PORT_A;
            tag2_valid <= tag1_valid;
            tag2_port  <= tag1_port;
        end
    end

    // Read return: the BRAM word is broadcast to both ports and only the
    // owner of the head tag sees rvalid.
    always_comb begin
        a_rvalid = tag2_valid && (tag2_port == PORT_A);
        b_rvalid = tag2_valid && (tag2_port == PORT_B);
        a_rdata  = mem_word_read;
        b_rdata  = mem_word_read;
    end

endmodule

// File: tb/tb_flapjack_mem_arb.sv
// ---------------------------------------------------------------------------
// tb_flapjack_mem_arb
//
// Testbench for flapjack_mem_arb. Provides a behavioural BRAM (registered
// read, synchronous write) and a reference model of the arbiter built from
// a "who was granted last" flag, a shadow copy of memory and a queue of
// expected read responses tagged with their due cycle.
//
// Ports: none (top-level bench).
// ---------------------------------------------------------------------------
module tb_flapjack_mem_arb;

    localparam int WIDTH = 16;
    localparam int ADDRW = 16;

    logic             clk_sys;
    logic             rst_n;
    logic             a_req, a_we, b_req, b_we;
    logic [ADDRW-1:0] a_addr, b_addr;
    logic [WIDTH-1:0] a_wdata, b_wdata;
    logic             a_gnt, a_rvalid, b_gnt, b_rvalid;
    logic [WIDTH-1:0] a_rdata, b_rdata;
    logic [ADDRW-1:0] mem_addr_read, mem_addr_write;
    logic [WIDTH-1:0] mem_word_write, mem_word_read;
    logic             mem_strobe;

    logic             pre_we;
    logic [ADDRW-1:0] pre_addr;
    logic [WIDTH-1:0] pre_data;
    logic [WIDTH-1:0] bram [0:65535];

    // Reference model state
    typedef struct {
        int          due;
        bit          port_b;
        logic [15:0] data;
    } rsp_t;

    rsp_t        rsp_q[$];
    bit          m_last_b;
    bit          pend_wr;
    logic [15:0] pend_addr, pend_data, m_raddr;
    logic [15:0] shadow [0:65535];
    int          cyc;

    int          check_count;
    int          pass_count;

    logic        obs_a_gnt, obs_b_gnt, obs_a_rvalid, obs_b_rvalid, obs_mem_strobe;
    logic [15:0] obs_a_rdata, obs_b_rdata;

    typedef struct {
        bit          a_req;
        bit          b_req;
        bit          exp_a_gnt;
        bit          exp_b_gnt;
        bit          exp_a_rvalid;
        bit          exp_b_rvalid;
        logic [15:0] exp_rdata;
    } vec_t;

    flapjack_mem_arb #(.WIDTH(WIDTH), .ADDRW(ADDRW)) dut (
        .clk_sys        (clk_sys),
        .rst_n          (rst_n),
        .a_req          (a_req),
        .a_we           (a_we),
        .a_addr         (a_addr),
        .a_wdata        (a_wdata),
        .a_gnt          (a_gnt),
        .a_rvalid       (a_rvalid),
        .a_rdata        (a_rdata),
        .b_req          (b_req),
        .b_we           (b_we),
        .b_addr         (b_addr),
        .b_wdata        (b_wdata),
        .b_gnt          (b_gnt),
        .b_rvalid       (b_rvalid),
        .b_rdata        (b_rdata),
        .mem_addr_read  (mem_addr_read),
        .mem_addr_write (mem_addr_write),
        .mem_word_write (mem_word_write),
        .mem_strobe     (mem_strobe),
        .mem_word_read  (mem_word_read)
    );

    // Free-running system clock, 10 time units per cycle.
    initial begin
        clk_sys = 1'b0;
        forever #5 clk_sys = ~clk_sys;
    end

    // Behavioural BRAM: preload port for the bench, strobed write port for
    // the DUT, and a registered read port.
    always @(posedge clk_sys) begin
        if (pre_we) begin
            bram[pre_addr] <= pre_data;
        end else if (mem_strobe) begin
            bram[mem_addr_write] <= mem_word_write;
        end
        mem_word_read <= bram[mem_addr_read];
    end

    // Safety net so the run always ends.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic logic [15:0] preVal(input int addr);
        if (addr == 256) return 16'hA100;
        if (addr == 512) return 16'hB200;
        return 16'hD000 | 16'(addr);
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual,
                               input logic [31:0] expected);
        check_count++;
        if (actual !== expected) begin
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end else begin
            pass_count++;
        end
    endtask

    // Assert reset, confirm outputs drop without waiting for a clock,
    // preload memory and model, then release at one unit past a rising edge.
    task automatic doReset();
        a_req = 1'b1;
        b_req = 1'b1;
        a_we  = 1'b0;
        b_we  = 1'b0;
        rst_n = 1'b0;
        #1;
        checkOutput("rst_a_gnt",      32'(a_gnt),          32'd0);
        checkOutput("rst_b_gnt",      32'(b_gnt),          32'd0);
        checkOutput("rst_a_rvalid",   32'(a_rvalid),       32'd0);
        checkOutput("rst_b_rvalid",   32'(b_rvalid),       32'd0);
        checkOutput("rst_mem_strobe", 32'(mem_strobe),     32'd0);
        checkOutput("rst_addr_read",  32'(mem_addr_read),  32'd0);
        checkOutput("rst_addr_write", 32'(mem_addr_write), 32'd0);
        checkOutput("rst_word_write", 32'(mem_word_write), 32'd0);
        a_req = 1'b0;
        b_req = 1'b0;
        @(posedge clk_sys);
        #1;
        for (int i = 0; i < 66; i++) begin
            int ad;
            ad       = (i < 64) ? i : ((i == 64) ? 256 : 512);
            pre_we   = 1'b1;
            pre_addr = 16'(ad);
            pre_data = preVal(ad);
            shadow[ad] = preVal(ad);
            @(posedge clk_sys);
            #1;
        end
        pre_we = 1'b0;
        rsp_q.delete();
        m_last_b = 1'b1;
        pend_wr  = 1'b0;
        m_raddr  = '0;
        cyc      = 0;
        rst_n    = 1'b1;
    endtask

    // One cycle: drive inputs, compare everything against the model mid-cycle,
    // let the model accept, then step to one unit past the next rising edge.
    task automatic applyStimulus(input bit ar, input bit aw, input logic [15:0] aa,
                                 input logic [15:0] ad, input bit br, input bit bw,
                                 input logic [15:0] ba, input logic [15:0] bd);
        bit   win_a, win_b, exp_av, exp_bv, w_we;
        logic [15:0] exp_data, w_addr, w_data;
        rsp_t r;
        a_req = ar; a_we = aw; a_addr = aa; a_wdata = ad;
        b_req = br; b_we = bw; b_addr = ba; b_wdata = bd;
        @(negedge clk_sys);
        obs_a_gnt      = a_gnt;
        obs_b_gnt      = b_gnt;
        obs_a_rvalid   = a_rvalid;
        obs_b_rvalid   = b_rvalid;
        obs_a_rdata    = a_rdata;
        obs_b_rdata    = b_rdata;
        obs_mem_strobe = mem_strobe;

        if (ar && br) begin
            win_a = m_last_b;
            win_b = !m_last_b;
        end else begin
            win_a = ar;
            win_b = br;
        end
        checkOutput($sformatf("a_gnt@%0d", cyc), 32'(a_gnt), 32'(win_a));
        checkOutput($sformatf("b_gnt@%0d", cyc), 32'(b_gnt), 32'(win_b));

        checkOutput($sformatf("mem_strobe@%0d", cyc), 32'(mem_strobe), 32'(pend_wr));
        if (pend_wr) begin
            checkOutput($sformatf("mem_addr_write@%0d", cyc), 32'(mem_addr_write), 32'(pend_addr));
            checkOutput($sformatf("mem_word_write@%0d", cyc), 32'(mem_word_write), 32'(pend_data));
        end
        checkOutput($sformatf("mem_addr_read@%0d", cyc), 32'(mem_addr_read), 32'(m_raddr));

        exp_av   = 1'b0;
        exp_bv   = 1'b0;
        exp_data = '0;
        if (rsp_q.size() > 0 && rsp_q[0].due == cyc) begin
            r = rsp_q.pop_front();
            exp_av   = !r.port_b;
            exp_bv   = r.port_b;
            exp_data = r.data;
        end
        checkOutput($sformatf("a_rvalid@%0d", cyc), 32'(a_rvalid), 32'(exp_av));
        checkOutput($sformatf("b_rvalid@%0d", cyc), 32'(b_rvalid), 32'(exp_bv));
        if (exp_av) checkOutput($sformatf("a_rdata@%0d", cyc), 32'(a_rdata), 32'(exp_data));
        if (exp_bv) checkOutput($sformatf("b_rdata@%0d", cyc), 32'(b_rdata), 32'(exp_data));

        pend_wr = 1'b0;
        if (win_a || win_b) begin
            w_we   = win_b ? bw : aw;
            w_addr = win_b ? ba : aa;
            w_data = win_b ? bd : ad;
            m_last_b = win_b;
            if (w_we) begin
                shadow[w_addr] = w_data;
                pend_wr   = 1'b1;
                pend_addr = w_addr;
                pend_data = w_data;
            end else begin
                m_raddr = w_addr;
                r.due    = cyc + 2;
                r.port_b = win_b;
                r.data   = shadow[w_addr];
                rsp_q.push_back(r);
            end
        end
        @(posedge clk_sys);
        #1;
        cyc++;
    endtask

    task automatic idleCycles(input int n);
        for (int i = 0; i < n; i++) begin
            applyStimulus(0, 0, 16'h0, 16'h0, 0, 0, 16'h0, 16'h0);
        end
    endtask

    initial begin
        vec_t vecs[14];
        bit   ar, aw, br, bw, b_done;
        logic [15:0] aa, ad, ba, bd;
        int   b_wait, strobes, rv_seen;

        check_count = 0;
        pass_count  = 0;
        rst_n  = 1'b1;
        pre_we = 1'b0;
        pre_addr = '0;
        pre_data = '0;
        a_req = 0; a_we = 0; a_addr = '0; a_wdata = '0;
        b_req = 0; b_we = 0; b_addr = '0; b_wdata = '0;
        cyc = 0;
        m_last_b = 1'b1;
        pend_wr = 1'b0;
        pend_addr = '0;
        pend_data = '0;
        m_raddr = '0;

        // Grant/rvalid sequence from reset: A reads 0x0100, B reads 0x0200.
        vecs[0]  = '{1, 1, 1, 0, 0, 0, 16'h0000};
        vecs[1]  = '{1, 1, 0, 1, 0, 0, 16'h0000};
        vecs[2]  = '{1, 1, 1, 0, 1, 0, 16'hA100};
        vecs[3]  = '{1, 1, 0, 1, 0, 1, 16'hB200};
        vecs[4]  = '{0, 0, 0, 0, 1, 0, 16'hA100};
        vecs[5]  = '{0, 1, 0, 1, 0, 1, 16'hB200};
        vecs[6]  = '{0, 1, 0, 1, 0, 0, 16'h0000};
        vecs[7]  = '{1, 1, 1, 0, 0, 1, 16'hB200};
        vecs[8]  = '{1, 0, 1, 0, 0, 1, 16'hB200};
        vecs[9]  = '{1, 1, 0, 1, 1, 0, 16'hA100};
        vecs[10] = '{1, 0, 1, 0, 1, 0, 16'hA100};
        vecs[11] = '{0, 0, 0, 0, 0, 1, 16'hB200};
        vecs[12] = '{0, 0, 0, 0, 1, 0, 16'hA100};
        vecs[13] = '{0, 0, 0, 0, 0, 0, 16'h0000};

        #2;
        doReset();

        for (int i = 0; i < 14; i++) begin
            applyStimulus(vecs[i].a_req, 0, 16'h0100, 16'h0,
                          vecs[i].b_req, 0, 16'h0200, 16'h0);
            checkOutput($sformatf("tbl%0d_a_gnt", i), 32'(obs_a_gnt), 32'(vecs[i].exp_a_gnt));
            checkOutput($sformatf("tbl%0d_b_gnt", i), 32'(obs_b_gnt), 32'(vecs[i].exp_b_gnt));
            checkOutput($sformatf("tbl%0d_a_rvalid", i), 32'(obs_a_rvalid), 32'(vecs[i].exp_a_rvalid));
            checkOutput($sformatf("tbl%0d_b_rvalid", i), 32'(obs_b_rvalid), 32'(vecs[i].exp_b_rvalid));
            if (vecs[i].exp_a_rvalid)
                checkOutput($sformatf("tbl%0d_a_rdata", i), 32'(obs_a_rdata), 32'(vecs[i].exp_rdata));
            if (vecs[i].exp_b_rvalid)
                checkOutput($sformatf("tbl%0d_b_rdata", i), 32'(obs_b_rdata), 32'(vecs[i].exp_rdata));
        end

        // Write then immediate read of the same address.
        applyStimulus(1, 1, 16'h0010, 16'h1234, 0, 0, 16'h0, 16'h0);
        applyStimulus(1, 0, 16'h0010, 16'h0,    0, 0, 16'h0, 16'h0);
        checkOutput("raw_strobe", 32'(obs_mem_strobe), 32'd1);
        idleCycles(1);
        applyStimulus(0, 0, 16'h0, 16'h0, 0, 0, 16'h0, 16'h0);
        checkOutput("raw_a_rvalid", 32'(obs_a_rvalid), 32'd1);
        checkOutput("raw_a_rdata",  32'(obs_a_rdata),  32'h1234);
        idleCycles(1);

        // B alone streams reads over 0x0000..0x0007.
        for (int i = 0; i < 8; i++) begin
            applyStimulus(0, 0, 16'h0, 16'h0, 1, 0, 16'(i), 16'h0);
        end
        idleCycles(2);

        // Quiet period: nothing moves and the read address is held.
        idleCycles(10);
        checkOutput("idle_addr_read", 32'(mem_addr_read), 32'h0007);

        // B write under contention from A reads; B drops req once accepted.
        b_done  = 1'b0;
        b_wait  = 0;
        strobes = 0;
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1, 0, 16'h0030, 16'h0, !b_done, 1, 16'h0020, 16'hBEEF);
            strobes += int'(obs_mem_strobe);
            if (!b_done && obs_b_gnt) b_done = 1'b1;
            else if (!b_done) b_wait++;
        end
        for (int i = 0; i < 2; i++) begin
            applyStimulus(0, 0, 16'h0, 16'h0, 0, 0, 16'h0, 16'h0);
            strobes += int'(obs_mem_strobe);
        end
        checkOutput("bwr_accepted",   32'(b_done),            32'd1);
        checkOutput("bwr_stall_le_1", 32'(b_wait <= 1),       32'd1);
        checkOutput("bwr_strobes",    32'(strobes),           32'd1);

        // Randomised traffic; a stalled requester keeps its request stable.
        ar = 0; aw = 0; aa = '0; ad = '0;
        br = 0; bw = 0; ba = '0; bd = '0;
        for (int i = 0; i < 300; i++) begin
            if (!(ar && !obs_a_gnt)) begin
                ar = ($urandom_range(0, 3) != 0);
                aw = ($urandom_range(0, 2) == 0);
                aa = 16'($urandom_range(0, 63));
                ad = 16'($urandom);
            end
            if (!(br && !obs_b_gnt)) begin
                br = ($urandom_range(0, 3) != 0);
                bw = ($urandom_range(0, 2) == 0);
                ba = 16'($urandom_range(0, 63));
                bd = 16'($urandom);
            end
            applyStimulus(ar, aw, aa, ad, br, bw, ba, bd);
        end
        idleCycles(3);

        // Reset pulsed while a read is in flight: the read must vanish.
        applyStimulus(1, 0, 16'h0005, 16'h0, 0, 0, 16'h0, 16'h0);
        #2;
        doReset();
        rv_seen = 0;
        for (int i = 0; i < 4; i++) begin
            applyStimulus(0, 0, 16'h0, 16'h0, 0, 0, 16'h0, 16'h0);
            rv_seen += int'(obs_a_rvalid) + int'(obs_b_rvalid);
        end
        checkOutput("rst_abort_rvalid", 32'(rv_seen), 32'd0);

        $display("%0d/%0d checks passed", pass_count, check_count);
        $finish;
    end

endmodule

// File: doc/flapjack_mem_arb.md
FLAPJACK_MEM_ARB -- requirements
Module: flapjack_mem_arb

Interface
Parameters:
REQ-001 The block SHALL have parameter WIDTH, default 16, giving the data word width.
REQ-002 The block SHALL have parameter ADDRW, default 16, giving the address width.

Ports:
REQ-003 The block SHALL have port clk_sys, input, 1 bit: the system clock. It is the single clock, and every flop is rising-edge.
REQ-004 The block SHALL have port rst_n, input, 1 bit: asynchronous, active-low reset.
REQ-005 The block SHALL have ports a_req, a_we, input, 1 bit each: port A (core) request and write-enable.
REQ-006 The block SHALL have ports a_addr [ADDRW] and a_wdata [WIDTH], inputs: port A address and write data.
REQ-007 The block SHALL have ports a_gnt, a_rvalid, output, 1 bit each: port A accept and read-data-valid.
REQ-008 The block SHALL have port a_rdata, output, WIDTH: port A read data.
REQ-009 The block SHALL provide identical ports b_req, b_we, b_addr, b_wdata, b_gnt, b_rvalid, b_rdata for port B (loader/debug).
REQ-010 The block SHALL have ports mem_addr_read and mem_addr_write, output, ADDRW each: BRAM read and write addresses.
REQ-011 The block SHALL have ports mem_word_write, output, WIDTH, and mem_strobe, output, 1 bit: BRAM write data and write enable.
REQ-012 The block SHALL have port mem_word_read, input, WIDTH: BRAM read data, registered, available 1 cycle after mem_addr_read.

Function
REQ-013 a_gnt and b_gnt SHALL be combinational from the req inputs and the priority pointer. At most one gnt SHALL be high in any cycle.
REQ-014 A transaction SHALL be accepted on the rising edge that ends a cycle with req=1 and gnt=1. The requester SHALL hold addr, we and wdata stable while req=1 and gnt=0.
REQ-015 Arbitration SHALL be round-robin with a 1-bit last-granted pointer:
- Only one port requesting: that port SHALL be granted every cycle, with no bubbles.
- Both ports requesting: the port that was not granted last SHALL be granted.
- The pointer SHALL update only on an accept.
REQ-016 Write accepted in cycle C: in cycle C+1 the block SHALL drive mem_strobe=1 for exactly one cycle, with mem_addr_write=addr and mem_word_write=wdata.
REQ-017 Read accepted in cycle C: the block SHALL register mem_addr_read=addr at the end of C. It SHALL assert the owner's rvalid for exactly one cycle, in C+2.
REQ-018 The owner's rdata SHALL equal mem_word_read during its rvalid cycle. The block SHALL route read data via a 2-stage owner tag pipeline {valid, port}.
REQ-019 Back-to-back reads SHALL be fully pipelined, one per cycle. rvalid SHALL return in acceptance order.
REQ-020 A read accepted in the cycle after a write to the same address SHALL return the new data (read-after-write ordering).
REQ-021 mem_addr_read SHALL hold its last value when no read is accepted. mem_strobe SHALL be 0 in every cycle without a write issue.
REQ-022 A port's rdata SHALL be don't-care while its rvalid=0. The bench SHALL check rdata only while rvalid=1.
REQ-023 Address arithmetic: the block SHALL NOT perform any, and SHALL pass addresses through unmodified.

Reset
REQ-024 While rst_n=0, the block SHALL hold the following values:
- a_gnt=b_gnt=0
- a_rvalid=b_rvalid=0
- mem_strobe=0
- mem_addr_read=mem_addr_write=0
- mem_word_write=0
- owner tags invalid
- pointer = B, so that A wins the first contention
REQ-025 Reset asserted mid-operation SHALL abort all in-flight reads, with no rvalid after release. A write already strobed SHALL complete. No write SHALL issue after reset asserts.
REQ-026 The first accept SHALL occur no earlier than the first rising edge after rst_n deasserts.

Verification
REQ-027 Scenario: A writes 0x1234 to addr 0x0010 in cycle 0, then A reads 0x0010 in cycle 1. Required response: mem_strobe=1 in cycle 1 with addr 0x0010; a_rvalid=1 with a_rdata=0x1234 in cycle 3.
REQ-028 Scenario: A and B both hold read requests for 4 cycles after reset, at addrs 0x0100 and 0x0200. Required response: grants alternate A,B,A,B; rvalid alternates A,B,A,B from cycle 2; each rdata matches its preloaded word.
REQ-029 Scenario: B alone reads addrs 0x0000..0x0007 on consecutive cycles. Required response: b_gnt=1 every cycle; b_rvalid=1 for cycles 2..9, with data in address order.
REQ-030 Scenario: A requests while B holds req=1 with we=1 (addr 0x0020, data 0xBEEF) for 3 cycles. Required response: B is stalled at most 1 cycle; exactly one mem_strobe with 0x0020/0xBEEF occurs.
REQ-031 Scenario: A reads in cycle 0 and rst_n is pulsed low in cycle 1. Required response: a_rvalid never asserts; all outputs reach their reset values immediately, with no clock edge needed.
REQ-032 Scenario: no requests for 10 cycles. Required response: mem_strobe=0; gnt=0 and rvalid=0 on both ports; mem_addr_read is unchanged.
